ex_mem_pipe: RTL and testbench
==============================

EX_MEM_PIPE -- requirements
Module: ex_mem_pipe

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the ALU result and store-data width.
REQ-002 The block SHALL have parameter RD_W, default 5, giving the destination register address width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: EX stage offers a beat.
REQ-006 The block SHALL have port in_ready, output, 1 bit: stage accepts the beat.
REQ-007 The block SHALL have port alu_res, input, DATA_W bits: ALU result or memory address.
REQ-008 The block SHALL have port store_data, input, DATA_W bits: data for store instructions.
REQ-009 The block SHALL have port byte_en, input, DATA_W/8 bits: store byte mask.
REQ-010 The block SHALL have port rd, input, RD_W bits: destination register.
REQ-011 The block SHALL have ports mem_read, mem_write, mem_to_reg and reg_write, each input, 1 bit: control bits.
REQ-012 The block SHALL have port flush, input, 1 bit: squash all held and incoming beats.
REQ-013 The block SHALL have ports out_valid (output, 1), out_ready (input, 1) and outputs alu_res_q, store_data_q, byte_en_q, rd_q, mem_read_q, mem_write_q, mem_to_reg_q, reg_write_q, each as wide as its input.
REQ-014 The block SHALL have port count, output, 2 bits: number of valid entries held (0..2).
REQ-015 The block SHALL have ports fwd_valid (output, 1), fwd_rd (output, RD_W) and fwd_data (output, DATA_W): the forwarding tap.

Function
REQ-016 Accept SHALL occur on in_valid && in_ready at the clock edge; release SHALL occur on out_valid && out_ready.
REQ-017 Latency SHALL be 1 cycle: a beat accepted into an empty stage appears on the outputs the next cycle.
REQ-018 Beats SHALL leave in acceptance order; no beat SHALL be duplicated or dropped except by flush.
REQ-019 The output payload SHALL always come from the main entry, and SHALL hold stable while out_valid && !out_ready.
REQ-020 mem_read_q, mem_write_q, mem_to_reg_q and reg_write_q SHALL each be ANDed with out_valid, so a bubble never issues a memory access or register write.
REQ-021 While out_valid is 0, the data payload outputs SHALL hold their last value and SHALL NOT be checked.
REQ-022 flush SHALL be synchronous and take priority: the next cycle, count=0 and out_valid=0, and a beat accepted in the flush cycle SHALL be discarded.
REQ-023 A simultaneous accept and release on a single occupied entry SHALL replace the entry with no bubble, leaving count unchanged.
REQ-024 fwd_valid SHALL equal reg_write_q && (rd_q != 0); fwd_rd SHALL equal rd_q and fwd_data SHALL equal alu_res_q.
REQ-025 fwd_valid SHALL be 0 when rd_q is 0 (register zero is never forwarded).
REQ-026 count SHALL never exceed the configured depth (1 without skid, 2 with skid).

Reset
REQ-027 When rst_n is low, the block SHALL immediately clear all entries, out_valid, count, all *_q outputs and fwd_valid to 0, independent of clk.
REQ-028 in_ready SHALL be 1 from the first cycle after rst_n deasserts.

Configuration
REQ-029 Macro EX_MEM_SKID_EN, when defined, SHALL add a second skid entry.
- in_ready SHALL be driven directly from a flop, as !skid_full.
- A beat accepted while main is full and not released SHALL go to skid.
- When main releases and skid is full, skid SHALL move to main the same edge.
REQ-030 Without EX_MEM_SKID_EN, the stage SHALL have a single entry with in_ready = !out_valid || out_ready (combinational path from out_ready).

Verification
REQ-031 Stream test: reset, out_ready=1, drive 8 back-to-back beats alu_res=1..8 -> outputs show 1..8 consecutively from cycle 1, count stays 1, no bubbles.
REQ-032 Back-pressure test (skid build): beats A=0x10, then B=0x20 with out_ready=0 -> count=2 and in_ready=0; raise out_ready -> A then B, in order.
REQ-033 Flush test: two entries held, flush=1 with in_valid=1 and C=0x30 -> the next cycle count=0 and out_valid=0, and C never appears.
REQ-034 Bubble-gating test: hold in_valid=0 with inputs mem_write=1, reg_write=1 -> mem_write_q=0, reg_write_q=0 and fwd_valid=0.
REQ-035 Forwarding test: beat with rd=0, reg_write=1 -> fwd_valid=0; beat with rd=7, alu_res=0xDEADBEEF -> fwd_valid=1, fwd_rd=7, fwd_data=0xDEADBEEF.
REQ-036 Async reset test: assert rst_n=0 mid-cycle with count=2 -> all outputs are 0 before the next clk edge.

Source files
------------

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline stage: one-entry valid/ready register with registered payload and forwarding tap.
// Define EX_MEM_SKID_EN to add a second (skid) entry so in_ready comes straight from a flop.
module ex_mem_pipe #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   alu_res,
    input  logic [DATA_W-1:0]   store_data,
    input  logic [DATA_W/8-1:0] byte_en,
    input  logic [RD_W-1:0]     rd,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic                mem_to_reg,
    input  logic                reg_write,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   alu_res_q,
    output logic [DATA_W-1:0]   store_data_q,
    output logic [DATA_W/8-1:0] byte_en_q,
    output logic [RD_W-1:0]     rd_q,
    output logic                mem_read_q,
    output logic                mem_write_q,
    output logic                mem_to_reg_q,
    output logic                reg_write_q,
    output logic [1:0]          count,
    output logic                fwd_valid,
    output logic [RD_W-1:0]     fwd_rd,
    output logic [DATA_W-1:0]   fwd_data
);

    localparam int BE_W = DATA_W / 8;
    localparam int PW   = 2 * DATA_W + BE_W + RD_W + 4;

    logic [PW-1:0] pay_in;
    logic [PW-1:0] pay_p1;
    logic          vld_p1;
    logic          take;
    logic          give;
    logic          mr_p1, mw_p1, mtr_p1, rw_p1;

    assign pay_in = {alu_res, store_data, byte_en, rd, mem_read, mem_write, mem_to_reg, reg_write};
    assign take   = in_valid && in_ready;
    assign give   = vld_p1 && out_ready;

`ifdef EX_MEM_SKID_EN
    logic [PW-1:0] pay_p0;
    logic          vld_p0;

    // Skid entry only fills while main is full, so vld_p0 implies vld_p1.
    assign in_ready = !vld_p0;
    assign count    = {vld_p0, vld_p1 & ~vld_p0};

    // Stage boundary: skid (p0) feeds main (p1); main drives the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            vld_p0 <= 1'b0;
            pay_p1 <= '0;
            pay_p0 <= '0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
            vld_p0 <= 1'b0;
        end else if (give) begin
            if (vld_p0) begin
                pay_p1 <= pay_p0;
                vld_p0 <= 1'b0;
            end else if (take) begin
                pay_p1 <= pay_in;
            end else begin
                vld_p1 <= 1'b0;
            end
        end else if (take) begin
            if (vld_p1) begin
                pay_p0 <= pay_in;
                vld_p0 <= 1'b1;
            end else begin
                pay_p1 <= pay_in;
                vld_p1 <= 1'b1;
            end
        end
    end
`else
    assign in_ready = !vld_p1 || out_ready;
    assign count    = {1'b0, vld_p1};

    // Stage boundary: single main entry (p1) drives the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            pay_p1 <= '0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (take) begin
            vld_p1 <= 1'b1;
            pay_p1 <= pay_in;
        end else if (give) begin
            vld_p1 <= 1'b0;
        end
    end
`endif

    assign {alu_res_q, store_data_q, byte_en_q, rd_q, mr_p1, mw_p1, mtr_p1, rw_p1} = pay_p1;

    // Control bits are gated so a bubble never issues a memory access or write-back.
    assign out_valid    = vld_p1;
    assign mem_read_q   = mr_p1  & vld_p1;
    assign mem_write_q  = mw_p1  & vld_p1;
    assign mem_to_reg_q = mtr_p1 & vld_p1;
    assign reg_write_q  = rw_p1  & vld_p1;

    assign fwd_valid = reg_write_q && (rd_q != '0);
    assign fwd_rd    = rd_q;
    assign fwd_data  = alu_res_q;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Directed bench for ex_mem_pipe: queue scoreboard of accepted beats, checked every cycle.
module tb_ex_mem_pipe;

`ifdef EX_MEM_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] sd;
        logic [3:0]  be;
        logic [4:0]  rd;
        logic        mr, mw, mtr, rw;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] alu_res, store_data;
    logic [3:0]  byte_en;
    logic [4:0]  rd;
    logic        mem_read, mem_write, mem_to_reg, reg_write;
    logic        flush;
    logic        out_valid, out_ready;
    logic [31:0] alu_res_q, store_data_q;
    logic [3:0]  byte_en_q;
    logic [4:0]  rd_q;
    logic        mem_read_q, mem_write_q, mem_to_reg_q, reg_write_q;
    logic [1:0]  count;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;

    int    vec  = 0;
    int    miss = 0;
    beat_t q[$];

    ex_mem_pipe #(.DATA_W(32), .RD_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_res(alu_res), .store_data(store_data), .byte_en(byte_en), .rd(rd),
        .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .alu_res_q(alu_res_q), .store_data_q(store_data_q), .byte_en_q(byte_en_q),
        .rd_q(rd_q), .mem_read_q(mem_read_q), .mem_write_q(mem_write_q),
        .mem_to_reg_q(mem_to_reg_q), .reg_write_q(reg_write_q), .count(count),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [31:0] a, input logic [4:0] r,
                         input logic rw, input logic mw);
        in_valid   = iv;
        alu_res    = a;
        store_data = a ^ 32'hA5A5_A5A5;
        byte_en    = a[3:0] ^ 4'h5;
        rd         = r;
        mem_read   = a[0];
        mem_to_reg = a[1];
        mem_write  = mw;
        reg_write  = rw;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, ".count"}, 64'(count), 64'd0);
        chk({tag, ".alu_res_q"}, 64'(alu_res_q), 64'd0);
        chk({tag, ".store_data_q"}, 64'(store_data_q), 64'd0);
        chk({tag, ".byte_en_q"}, 64'(byte_en_q), 64'd0);
        chk({tag, ".rd_q"}, 64'(rd_q), 64'd0);
        chk({tag, ".ctl_q"}, 64'({mem_read_q, mem_write_q, mem_to_reg_q, reg_write_q}), 64'd0);
        chk({tag, ".fwd_valid"}, 64'(fwd_valid), 64'd0);
    endtask

    // Called just after a falling edge with inputs already driven; advances one clock.
    task automatic cycle(input string tag);
        logic  exp_rdy, tk, gv;
        beat_t cur, h;
        #1;
        exp_rdy = SKID ? (q.size() < 2) : (q.size() == 0 || out_ready);
        chk({tag, ".in_ready"}, 64'(in_ready), 64'(exp_rdy));
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(q.size() != 0));
        chk({tag, ".count"}, 64'(count), 64'(q.size()));
        if (q.size() != 0) begin
            h = q[0];
            chk({tag, ".alu_res_q"}, 64'(alu_res_q), 64'(h.alu));
            chk({tag, ".store_data_q"}, 64'(store_data_q), 64'(h.sd));
            chk({tag, ".byte_en_q"}, 64'(byte_en_q), 64'(h.be));
            chk({tag, ".rd_q"}, 64'(rd_q), 64'(h.rd));
            chk({tag, ".ctl_q"}, 64'({mem_read_q, mem_write_q, mem_to_reg_q, reg_write_q}),
                64'({h.mr, h.mw, h.mtr, h.rw}));
            chk({tag, ".fwd_valid"}, 64'(fwd_valid), 64'(h.rw && h.rd != 5'd0));
            chk({tag, ".fwd_rd"}, 64'(fwd_rd), 64'(h.rd));
            chk({tag, ".fwd_data"}, 64'(fwd_data), 64'(h.alu));
        end else begin
            chk({tag, ".ctl_q_bubble"}, 64'({mem_read_q, mem_write_q, mem_to_reg_q, reg_write_q}), 64'd0);
            chk({tag, ".fwd_valid_bubble"}, 64'(fwd_valid), 64'd0);
        end
        cur = '{alu: alu_res, sd: store_data, be: byte_en, rd: rd,
                mr: mem_read, mw: mem_write, mtr: mem_to_reg, rw: reg_write};
        tk = in_valid && exp_rdy;
        gv = (q.size() != 0) && out_ready;
        @(posedge clk);
        if (flush) begin
            q.delete();
        end else begin
            if (gv) void'(q.pop_front());
            if (tk) q.push_back(cur);
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Stream: 8 back-to-back beats, no bubbles
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 32'(i), 5'(i), 1'b1, 1'b0);
            cycle("stream");
        end
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        cycle("stream_drain");
        cycle("stream_idle");

        // Back-pressure: A then B with out_ready low
        out_ready = 1'b0;
        drive(1'b1, 32'h10, 5'd1, 1'b1, 1'b1);
        cycle("bp_a");
        drive(1'b1, 32'h20, 5'd2, 1'b1, 1'b0);
        cycle("bp_b");
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        cycle("bp_hold");
        cycle("bp_hold2");
        out_ready = 1'b1;
        repeat (3) cycle("bp_drain");

        // Flush with an incoming beat C
        out_ready = 1'b0;
        drive(1'b1, 32'h11, 5'd3, 1'b1, 1'b0);
        cycle("fl_load1");
        drive(1'b1, 32'h12, 5'd4, 1'b1, 1'b0);
        cycle("fl_load2");
        drive(1'b1, 32'h30, 5'd5, 1'b1, 1'b1);
        flush = 1'b1;
        cycle("fl_flush");
        flush = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        out_ready = 1'b1;
        repeat (3) cycle("fl_after");

        // Bubble gating: control inputs high but nothing valid
        drive(1'b0, 32'h0, 5'd3, 1'b1, 1'b1);
        repeat (2) cycle("bubble");

        // Forwarding: rd=0 is never forwarded
        drive(1'b1, 32'h55, 5'd0, 1'b1, 1'b0);
        cycle("fwd_r0");
        drive(1'b1, 32'hDEAD_BEEF, 5'd7, 1'b1, 1'b0);
        cycle("fwd_r7");
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        cycle("fwd_out");
        chk("fwd_dir.valid", 64'(fwd_valid), 64'd0);

        // Random traffic
        for (int i = 0; i < 40; i++) begin
            out_ready = 1'($urandom_range(0, 3) != 0);
            drive(1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            cycle("rand");
        end

        // Asynchronous reset mid-cycle with the stage full
        out_ready = 1'b0;
        drive(1'b1, 32'h40, 5'd9, 1'b1, 1'b1);
        cycle("ar_load1");
        drive(1'b1, 32'h41, 5'd10, 1'b1, 1'b1);
        cycle("ar_load2");
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        #1;
        chk("ar.count_before", 64'(count), 64'(q.size()));
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (2) cycle("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
